// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester handshakes, TX FIFO write port and status of the TX arbiter
interface uart_tx_arbiter_if #(
   parameter int WIDTH = 32
);
   logic             req0_valid;
   logic [WIDTH-1:0] req0_data;
   logic [1:0]       req0_strb;
   logic             req0_ready;
   logic             req0_done;
   logic             req0_err;
   logic             req1_valid;
   logic [WIDTH-1:0] req1_data;
   logic [1:0]       req1_strb;
   logic             req1_ready;
   logic             req1_done;
   logic             req1_err;
   logic             fifo_wr_en;
   logic [WIDTH-1:0] fifo_wdata;
   logic [1:0]       fifo_strb;
   logic             fifo_full;
   logic             grant_id;
   logic             arb_busy;

   modport slave (
      input  req0_valid, req0_data, req0_strb, req1_valid, req1_data, req1_strb, fifo_full,
      output req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err,
             fifo_wr_en, fifo_wdata, fifo_strb, grant_id, arb_busy
   );

   modport master (
      output req0_valid, req0_data, req0_strb, req1_valid, req1_data, req1_strb, fifo_full,
      input  req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err,
             fifo_wr_en, fifo_wdata, fifo_strb, grant_id, arb_busy
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two-port round-robin arbiter writing one word per handshake into the UART TX FIFO
// Optional full-stall abort enabled by defining UART_ARB_TIMEOUT_EN (adds parameter TIMEOUT)
module uart_tx_arbiter #(
   parameter int WIDTH = 32
`ifdef UART_ARB_TIMEOUT_EN
   , parameter int TIMEOUT = 1024
`endif
) (
   input logic              clk,
   input logic              rst,
   uart_tx_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic             r_rr;
   logic             r_grant;
   logic             r_err;
   logic [WIDTH-1:0] r_data;
   logic [1:0]       r_strb;
   logic             w_sel;
   logic             w_xfer;
   logic             w_bad;
   logic             w_wr;
   logic             w_tmo;

   // rr only breaks ties; ready is held low while reset is asserted
   assign w_sel  = (bus.req0_valid && bus.req1_valid) ? r_rr : bus.req1_valid;
   assign w_xfer = rst && (r_state == IDLE) && (bus.req0_valid || bus.req1_valid);
   assign w_bad  = r_strb == 2'b11;
   assign w_wr   = (r_state == WRITE) && !w_bad && !bus.fifo_full;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CW-1:0] r_cnt;

   // stall counter: cleared on entry to WRITE, counts cycles spent waiting on a full FIFO
   always_ff @(posedge clk or negedge rst)
      if (!rst) r_cnt <= '0;
      else if (w_xfer) r_cnt <= '0;
      else if (r_state == WRITE && bus.fifo_full) r_cnt <= r_cnt + 1'b1;

   assign w_tmo = (r_state == WRITE) && !w_bad && bus.fifo_full && (r_cnt == CW'(TIMEOUT - 1));
`else
   assign w_tmo = 1'b0;
`endif

   // state register
   always_ff @(posedge clk or negedge rst)
      if (!rst) r_state <= IDLE;
      else r_state <= w_next;

   // next state: a transfer leaves IDLE, a write/error/abort leaves WRITE, DONE lasts one cycle
   always_comb
      w_next = (r_state == IDLE)  ? (w_xfer ? WRITE : IDLE) :
               (r_state == WRITE) ? ((w_bad || w_wr || w_tmo) ? DONE : WRITE) : IDLE;

   // transfer latch, error flag and round-robin pointer
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_rr    <= 1'b0;
         r_grant <= 1'b0;
         r_err   <= 1'b0;
         r_data  <= '0;
         r_strb  <= '0;
      end else begin
         if (w_xfer) begin
            r_grant <= w_sel;
            r_data  <= w_sel ? bus.req1_data : bus.req0_data;
            r_strb  <= w_sel ? bus.req1_strb : bus.req0_strb;
         end
         if (r_state == WRITE && (w_bad || w_tmo)) r_err <= 1'b1;
         if (r_state == DONE) begin
            r_rr  <= !r_grant;
            r_err <= 1'b0;
         end
      end

   // outputs: handshakes, FIFO write strobe, completion pulses and status
   always_comb begin
      bus.req0_ready = w_xfer && !w_sel;
      bus.req1_ready = w_xfer && w_sel;
      bus.fifo_wr_en = w_wr;
      bus.fifo_wdata = r_data;
      bus.fifo_strb  = r_strb;
      bus.req0_done  = (r_state == DONE) && !r_grant;
      bus.req1_done  = (r_state == DONE) && r_grant;
      bus.req0_err   = (r_state == DONE) && !r_grant && r_err;
      bus.req1_err   = (r_state == DONE) && r_grant && r_err;
      bus.grant_id   = r_grant;
      bus.arb_busy   = r_state != IDLE;
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad = 0;

   uart_tx_arbiter_if #(.WIDTH(32)) bus ();

   uart_tx_arbiter #(
      .WIDTH(32)
`ifdef UART_ARB_TIMEOUT_EN
      , .TIMEOUT(8)
`endif
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.req0_valid = 1'b0;
      bus.req0_data  = '0;
      bus.req0_strb  = '0;
      bus.req1_valid = 1'b0;
      bus.req1_data  = '0;
      bus.req1_strb  = '0;
      bus.fifo_full  = 1'b0;
   endtask

   task automatic test_reset();
      logic [8:0] flags;
      idle_inputs();
      rst = 1'b0;
      step();
      step();
      #1;
      flags = {bus.req0_ready, bus.req0_done, bus.req0_err, bus.req1_ready, bus.req1_done,
               bus.req1_err, bus.fifo_wr_en, bus.grant_id, bus.arb_busy};
      total++;
      if (flags !== 9'b0) begin bad++; $display("FAIL reset_flags got=%b exp=%b", flags, 9'b0); end
      total++;
      if (bus.fifo_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", bus.fifo_wdata); end
      total++;
      if (bus.fifo_strb !== 2'b00) begin bad++; $display("FAIL reset_strb got=%b exp=00", bus.fifo_strb); end
      rst = 1'b1;
      step();
   endtask

   task automatic test_single();
      bus.req0_valid = 1'b1;
      bus.req0_data  = 32'hDEADBEEF;
      bus.req0_strb  = 2'b10;
      #1;
      total++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin bad++; $display("FAIL single_ready got=%b exp=10", {bus.req0_ready, bus.req1_ready}); end
      step();
      idle_inputs();
      #1;
      total++;
      if ({bus.fifo_wr_en, bus.arb_busy, bus.grant_id} !== 3'b110) begin bad++; $display("FAIL single_wr got=%b exp=110", {bus.fifo_wr_en, bus.arb_busy, bus.grant_id}); end
      total++;
      if (bus.fifo_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_wdata got=%h exp=deadbeef", bus.fifo_wdata); end
      total++;
      if (bus.fifo_strb !== 2'b10) begin bad++; $display("FAIL single_strb got=%b exp=10", bus.fifo_strb); end
      step();
      #1;
      total++;
      if ({bus.req0_done, bus.req0_err, bus.req1_done, bus.fifo_wr_en} !== 4'b1000) begin bad++; $display("FAIL single_done got=%b exp=1000", {bus.req0_done, bus.req0_err, bus.req1_done, bus.fifo_wr_en}); end
      step();
      #1;
      total++;
      if ({bus.arb_busy, bus.req0_done} !== 2'b00) begin bad++; $display("FAIL single_idle got=%b exp=00", {bus.arb_busy, bus.req0_done}); end
   endtask

   task automatic test_stall();
      int writes = 0;
      bus.fifo_full  = 1'b1;
      bus.req1_valid = 1'b1;
      bus.req1_data  = 32'h0000A5A5;
      bus.req1_strb  = 2'b01;
      #1;
      total++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin bad++; $display("FAIL stall_ready got=%b exp=01", {bus.req0_ready, bus.req1_ready}); end
      step();
      bus.req1_valid = 1'b0;
      bus.req1_data  = 32'hFFFFFFFF;
      for (int c = 1; c <= 10; c++) begin
         #1;
         if (bus.fifo_wr_en) writes++;
         total++;
         if ({bus.arb_busy, bus.req1_done} !== 2'b10) begin bad++; $display("FAIL stall_hold cyc=%0d got=%b exp=10", c, {bus.arb_busy, bus.req1_done}); end
         step();
      end
      total++;
      if (writes !== 0) begin bad++; $display("FAIL stall_nowrite got=%0d exp=0", writes); end
      bus.fifo_full = 1'b0;
      #1;
      total++;
      if (bus.fifo_wr_en !== 1'b1 || bus.fifo_wdata !== 32'h0000A5A5 || bus.fifo_strb !== 2'b01) begin bad++; $display("FAIL stall_write got=%b/%h/%b exp=1/0000a5a5/01", bus.fifo_wr_en, bus.fifo_wdata, bus.fifo_strb); end
      step();
      #1;
      total++;
      if ({bus.req1_done, bus.req1_err, bus.req0_done, bus.fifo_wr_en, bus.grant_id} !== 5'b10001) begin bad++; $display("FAIL stall_done got=%b exp=10001", {bus.req1_done, bus.req1_err, bus.req0_done, bus.fifo_wr_en, bus.grant_id}); end
      step();
      #1;
      total++;
      if ({bus.arb_busy, bus.fifo_wr_en} !== 2'b00) begin bad++; $display("FAIL stall_idle got=%b exp=00", {bus.arb_busy, bus.fifo_wr_en}); end
   endtask

   task automatic test_round_robin();
      logic [31:0] want [6];
      int n = 0;
      int last = -1;
      want = '{32'h11, 32'h22, 32'h11, 32'h22, 32'h11, 32'h22};
      bus.req0_valid = 1'b1;
      bus.req0_data  = 32'h11;
      bus.req0_strb  = 2'b10;
      bus.req1_valid = 1'b1;
      bus.req1_data  = 32'h22;
      bus.req1_strb  = 2'b10;
      for (int c = 0; c < 40 && n < 6; c++) begin
         #1;
         total++;
         if (bus.req0_ready && bus.req1_ready) begin bad++; $display("FAIL rr_both_ready cyc=%0d got=11 exp=not 11", c); end
         if (bus.fifo_wr_en) begin
            total++;
            if (bus.fifo_wdata !== want[n]) begin bad++; $display("FAIL rr_word idx=%0d got=%h exp=%h", n, bus.fifo_wdata, want[n]); end
            if (n > 0) begin
               total++;
               if (c - last != 3) begin bad++; $display("FAIL rr_spacing idx=%0d got=%0d exp=3", n, c - last); end
            end
            last = c;
            n++;
            if (n == 6) idle_inputs();
         end
         step();
      end
      total++;
      if (n !== 6) begin bad++; $display("FAIL rr_count got=%0d exp=6", n); end
      step();
      #1;
      total++;
      if (bus.arb_busy !== 1'b0) begin bad++; $display("FAIL rr_idle got=%b exp=0", bus.arb_busy); end
   endtask

   task automatic test_illegal_strb();
      bus.req0_valid = 1'b1;
      bus.req0_data  = 32'h1234;
      bus.req0_strb  = 2'b11;
      #1;
      total++;
      if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL err_ready got=%b exp=1", bus.req0_ready); end
      step();
      idle_inputs();
      #1;
      total++;
      if ({bus.fifo_wr_en, bus.arb_busy} !== 2'b01) begin bad++; $display("FAIL err_nowrite got=%b exp=01", {bus.fifo_wr_en, bus.arb_busy}); end
      step();
      #1;
      total++;
      if ({bus.req0_done, bus.req0_err, bus.req1_done, bus.req1_err, bus.fifo_wr_en} !== 5'b11000) begin bad++; $display("FAIL err_done got=%b exp=11000", {bus.req0_done, bus.req0_err, bus.req1_done, bus.req1_err, bus.fifo_wr_en}); end
      step();
      #1;
      total++;
      if ({bus.req0_done, bus.req0_err, bus.arb_busy} !== 3'b000) begin bad++; $display("FAIL err_clear got=%b exp=000", {bus.req0_done, bus.req0_err, bus.arb_busy}); end
   endtask

   task automatic test_reset_mid();
      logic [8:0] flags;
      bus.fifo_full  = 1'b1;
      bus.req0_valid = 1'b1;
      bus.req0_data  = 32'hBAD0BAD0;
      bus.req0_strb  = 2'b10;
      #1;
      total++;
      if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", bus.req0_ready); end
      step();
      bus.req0_valid = 1'b0;
      step();
      #1;
      total++;
      if ({bus.arb_busy, bus.fifo_wr_en} !== 2'b10) begin bad++; $display("FAIL rstmid_stalled got=%b exp=10", {bus.arb_busy, bus.fifo_wr_en}); end
      rst = 1'b0;
      bus.req0_valid = 1'b1;
      bus.req0_data  = 32'h11;
      bus.req1_valid = 1'b1;
      bus.req1_data  = 32'h22;
      bus.req1_strb  = 2'b10;
      #1;
      flags = {bus.req0_ready, bus.req0_done, bus.req0_err, bus.req1_ready, bus.req1_done,
               bus.req1_err, bus.fifo_wr_en, bus.grant_id, bus.arb_busy};
      total++;
      if (flags !== 9'b0 || bus.fifo_wdata !== 32'h0 || bus.fifo_strb !== 2'b00) begin bad++; $display("FAIL rstmid_outputs got=%b/%h/%b exp=0/0/0", flags, bus.fifo_wdata, bus.fifo_strb); end
      step();
      step();
      bus.fifo_full = 1'b0;
      rst = 1'b1;
      #1;
      total++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin bad++; $display("FAIL rstmid_first_grant got=%b exp=10", {bus.req0_ready, bus.req1_ready}); end
      step();
      idle_inputs();
      #1;
      total++;
      if (bus.fifo_wr_en !== 1'b1 || bus.fifo_wdata !== 32'h11) begin bad++; $display("FAIL rstmid_write got=%b/%h exp=1/00000011", bus.fifo_wr_en, bus.fifo_wdata); end
      step();
      #1;
      total++;
      if ({bus.req0_done, bus.req0_err, bus.req1_done} !== 3'b100) begin bad++; $display("FAIL rstmid_done got=%b exp=100", {bus.req0_done, bus.req0_err, bus.req1_done}); end
      step();
   endtask

`ifdef UART_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int early = 0;
      bus.fifo_full  = 1'b1;
      bus.req0_valid = 1'b1;
      bus.req0_data  = 32'h0BADF00D;
      bus.req0_strb  = 2'b10;
      #1;
      total++;
      if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL tmo_ready got=%b exp=1", bus.req0_ready); end
      step();
      bus.req0_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         #1;
         if (bus.req0_done || bus.fifo_wr_en) early++;
         step();
      end
      total++;
      if (early !== 0) begin bad++; $display("FAIL tmo_early got=%0d exp=0", early); end
      #1;
      total++;
      if ({bus.req0_done, bus.req0_err, bus.fifo_wr_en} !== 3'b110) begin bad++; $display("FAIL tmo_done got=%b exp=110", {bus.req0_done, bus.req0_err, bus.fifo_wr_en}); end
      bus.fifo_full = 1'b0;
      step();
      #1;
      total++;
      if ({bus.arb_busy, bus.fifo_wr_en, bus.req0_done} !== 3'b000) begin bad++; $display("FAIL tmo_idle got=%b exp=000", {bus.arb_busy, bus.fifo_wr_en, bus.req0_done}); end
   endtask
`else
   task automatic test_no_timeout();
      int seen = 0;
      bus.fifo_full  = 1'b1;
      bus.req1_valid = 1'b1;
      bus.req1_data  = 32'h0BADF00D;
      bus.req1_strb  = 2'b10;
      #1;
      total++;
      if (bus.req1_ready !== 1'b1) begin bad++; $display("FAIL notmo_ready got=%b exp=1", bus.req1_ready); end
      step();
      bus.req1_valid = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         #1;
         if (bus.req1_done || bus.fifo_wr_en || !bus.arb_busy) seen++;
         step();
      end
      total++;
      if (seen !== 0) begin bad++; $display("FAIL notmo_wait got=%0d exp=0", seen); end
      bus.fifo_full = 1'b0;
      #1;
      total++;
      if (bus.fifo_wr_en !== 1'b1 || bus.fifo_wdata !== 32'h0BADF00D) begin bad++; $display("FAIL notmo_write got=%b/%h exp=1/0badf00d", bus.fifo_wr_en, bus.fifo_wdata); end
      step();
      #1;
      total++;
      if ({bus.req1_done, bus.req1_err} !== 2'b10) begin bad++; $display("FAIL notmo_done got=%b exp=10", {bus.req1_done, bus.req1_err}); end
      step();
   endtask
`endif

   initial begin
      idle_inputs();
      @(negedge clk);
      test_reset();
      test_single();
      test_stall();
      test_round_robin();
      test_illegal_strb();
      test_reset_mid();
`ifdef UART_ARB_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
